// File: rtl/serial_adder_seq.sv
// Multi-cycle ripple adder: BPC bits per clock through a full-adder slice and a registered carry.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NSTEP = WIDTH / BPC;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    logic [BPC-1:0]   digit;
    logic             cy_out;
    logic             cy_msb;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // Carry chain walked with a scalar so the slice has no self-referencing vector.
    always_comb begin
        logic cy;
        digit  = '0;
        cy     = carry_q;
        cy_msb = 1'b0;
        for (int unsigned i = 0; i < BPC; i++) begin
            cy_msb   = cy;
            digit[i] = a_q[i] ^ b_q[i] ^ cy;
            cy       = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
        end
        cy_out   = cy;
        acc_next = WIDTH'({digit, acc_q} >> BPC);
    end

    assign last = (step_q == SW'(NSTEP - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        step_d  = step_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = cy_out;
                acc_d   = acc_next;
                step_d  = step_q + SW'(1);
                if (last) begin
                    state_d = S_DONE;
                    sum_d   = acc_next;
                    cout_d  = cy_out;
                    ovf_d   = cy_msb ^ cy_out;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    step_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: WIDTH=8 with BPC=1 and BPC=4 instances, scoreboard queues.
module tb_serial_adder_seq;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start4;
    logic [7:0] a, b;
    logic       cin, sub;

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    res_t q1[$];
    res_t q4[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    serial_adder_seq #(.WIDTH(8), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    function automatic res_t model(input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci, input logic sb);
        logic [7:0] bb;
        logic [8:0] full;
        res_t r;
        bb   = sb ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bb} + {8'b0, (sb ? 1'b1 : ci)};
        r.s  = full[7:0];
        r.c  = full[8];
        r.v  = (av[7] == bb[7]) && (full[7] != av[7]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the BPC=1 instance; optionally pulses start at RUN edge 'poke'.
    task automatic wait1(input int lat, input int poke);
        int   n;
        res_t e;
        n = 0;
        while (!done1 && n < 40) begin
            if (n == poke) begin
                start1 = 1'b1;
                a = 8'h33;
                b = 8'h44;
            end
            tick();
            start1 = 1'b0;
            n++;
        end
        chk("lat1", n, lat);
        if (done1 && q1.size() > 0) begin
            e = q1.pop_front();
            chk("sum1", sum1, e.s);
            chk("cout1", cout1, e.c);
            chk("ovf1", ovf1, e.v);
            chk("busy1_at_done", busy1, 0);
            tick();
            chk("done1_one_cycle", done1, 0);
            chk("sum1_held", sum1, e.s);
        end
    endtask

    task automatic op1(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic sb, input int poke);
        a = av; b = bv; cin = ci; sub = sb; start1 = 1'b1;
        q1.push_back(model(av, bv, ci, sb));
        tick();
        start1 = 1'b0;
        chk("busy1_after_accept", busy1, 1);
        wait1(8, poke);
    endtask

    task automatic wait4(input int lat);
        int   n;
        res_t e;
        n = 0;
        while (!done4 && n < 40) begin
            tick();
            n++;
        end
        chk("lat4", n, lat);
        if (done4 && q4.size() > 0) begin
            e = q4.pop_front();
            chk("sum4", sum4, e.s);
            chk("cout4", cout4, e.c);
            chk("ovf4", ovf4, e.v);
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_sum", sum1, 0);
        chk("rst_cout", cout1, 0);
        chk("rst_ovf", ovf1, 0);
        rst = 1'b0;
        tick();

        op1(8'h0F, 8'h01, 1'b0, 1'b0, -1);
        op1(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        op1(8'h7F, 8'h01, 1'b0, 1'b0, -1);
        op1(8'hFF, 8'hFF, 1'b1, 1'b0, 2);

        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done1) cnt++;
        end
        chk("ignored_start_no_done", cnt, 0);

        // Abort a run with async reset after four RUN edges.
        a = 8'h12; b = 8'h34; cin = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_sum", sum1, 0);
        chk("abort_cout", cout1, 0);
        chk("abort_ovf", ovf1, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        op1(8'h3C, 8'h4B, 1'b1, 1'b0, -1);

        // BPC=4, back-to-back via start in the DONE cycle.
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0; start4 = 1'b1;
        q4.push_back(model(8'hA5, 8'h5A, 1'b1, 1'b0));
        tick();
        start4 = 1'b0;
        chk("busy4_after_accept", busy4, 1);
        wait4(2);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start4 = 1'b1;
        q4.push_back(model(8'h7F, 8'h01, 1'b0, 1'b0));
        tick();
        start4 = 1'b0;
        chk("b2b_done_drops", done4, 0);
        chk("b2b_busy_rises", busy4, 1);
        wait4(2);

`ifdef SERIAL_ADDER_SUB_EN
        op1(8'h05, 8'h07, 1'b0, 1'b1, -1);
        op1(8'h80, 8'h01, 1'b1, 1'b1, -1);
`endif

        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
